// File: rtl/srl_fifo_pkg.sv
// Shared sizing defaults and the per-edge operation encoding for the
// shift-register FIFO and its storage array.
package srl_fifo_pkg;

   localparam int DATA_WIDTH         = 16;
   localparam int SRL_FIFO_DEPTH     = 32;
   localparam int SRL_FIFO_AF_MARGIN = 4;

   // Combination of accepted write / read on one enabled edge.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10,
      OP_RW   = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/srl_mem.sv
// Clock-enabled shift array with a combinational addressed tap.
// Deliberately has no reset, so it can map onto SRL primitives.
module srl_mem
   import srl_fifo_pkg::*;
#(
   parameter int WIDTH = 2 * DATA_WIDTH,
   parameter int DEPTH = SRL_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             ce,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   input  logic [AW-1:0]    addr,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Newest word enters at index 0; everything else moves one place deeper.
   always_ff @(posedge clk) begin
      if (ce && shift) begin
         mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   assign q = mem[addr];

endmodule

// File: rtl/srl_fifo.sv
// Shift-register FIFO: occupancy counter, accept logic, registered read
// port, level flags and sticky error flags around a single srl_mem.
// The oldest word always sits at index count-1, so no wrapping pointers.
module srl_fifo
   import srl_fifo_pkg::*;
#(
   parameter int WIDTH    = 2 * DATA_WIDTH,
   parameter int DEPTH    = SRL_FIFO_DEPTH,
   parameter int AW       = $clog2(DEPTH),
   parameter int AF_LEVEL = DEPTH - SRL_FIFO_AF_MARGIN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic [AW:0]      count,
   output logic             ovf,
   output logic             udf
);

   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
   localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
   localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};

   logic             wr_acc;
   logic             rd_acc;
   fifo_op_e         op;
   logic [AW:0]      count_nxt;
   logic [AW:0]      count_m1;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] mem_q;

   assign wr_acc   = wr_en & ~full;
   assign rd_acc   = rd_en & ~empty;
   assign op       = fifo_op_e'({wr_acc, rd_acc});
   // When empty this wraps to all ones, but rd_acc is low so it is never used.
   assign count_m1 = count - ONE_C;
   assign rd_addr  = count_m1[AW-1:0];

   srl_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .ce    (ce),
      .shift (wr_acc),
      .din   (din),
      .addr  (rd_addr),
      .q     (mem_q)
   );

   // Next occupancy; a simultaneous read and write leaves it unchanged.
   always_comb begin
      count_nxt = count;
      unique case (op)
         OP_WR:   count_nxt = count + ONE_C;
         OP_RD:   count_nxt = count_m1;
         default: count_nxt = count;
      endcase
   end

   // Occupancy and level flags, all registered from the same next count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= '0;
         full        <= 1'b0;
         empty       <= 1'b1;
         almost_full <= (AF_C == '0);
      end else if (ce) begin
         count       <= count_nxt;
         full        <= (count_nxt == DEPTH_C);
         empty       <= (count_nxt == '0);
         almost_full <= (count_nxt >= AF_C);
      end
   end

   // Read port: the tap is taken before the shift, so it is the pre-edge oldest word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (ce) begin
         dout_valid <= rd_acc;
         if (rd_acc) begin
            dout <= mem_q;
         end
      end
   end

   // Sticky error flags; only a reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else if (ce) begin
         ovf <= ovf | (wr_en & full);
         udf <= udf | (rd_en & empty);
      end
   end

endmodule

// File: tb/tb_srl_fifo.sv
module tb_srl_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic             clk;
   logic             rst_n;
   logic             ce;
   logic             wr_en;
   logic [WIDTH-1:0] din;
   logic             rd_en;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic [AW:0]      count;
   logic             ovf;
   logic             udf;

   int n_cmp;
   int n_err;

   srl_fifo dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ce          (ce),
      .wr_en       (wr_en),
      .din         (din),
      .rd_en       (rd_en),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .count       (count),
      .ovf         (ovf),
      .udf         (udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ce;
      logic        wr;
      logic        rd;
      logic [31:0] din;
      int          cnt;
      logic [31:0] dout;
      logic        dv;
      logic        full;
      logic        empty;
      logic        af;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge; return just after the rising edge.
   task automatic step(input logic c, input logic w, input logic [31:0] d, input logic r);
      @(negedge clk);
      ce    = c;
      wr_en = w;
      din   = d;
      rd_en = r;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic c, input logic w, input logic r, input int d,
                               input int cnt, input int dq, input logic dv,
                               input logic f, input logic e, input logic af);
      vec_t v;
      v.ce = c; v.wr = w; v.rd = r; v.din = 32'(d);
      v.cnt = cnt; v.dout = 32'(dq); v.dv = dv;
      v.full = f; v.empty = e; v.af = af;
      return v;
   endfunction

   initial begin
      n_cmp = 0;
      n_err = 0;
      ce    = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      din   = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #10;

      // Reset state
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full",  32'(full), 0);
      check("rst_af",    32'(almost_full), 0);
      check("rst_dout",  dout, 0);
      check("rst_dv",    32'(dout_valid), 0);
      check("rst_ovf",   32'(ovf), 0);
      check("rst_udf",   32'(udf), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill 1..32
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b1, 1'b1, 32'(i), 1'b0);
         check("fill_count", 32'(count), 32'(i));
         check("fill_full",  32'(full), (i == DEPTH) ? 1 : 0);
         check("fill_af",    32'(almost_full), (i >= 28) ? 1 : 0);
         check("fill_empty", 32'(empty), 0);
      end

      // Overflow: writes of 99 while full are dropped
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 32'd99, 1'b0);
         check("ovf_count", 32'(count), 32);
         check("ovf_flag",  32'(ovf), 1);
         check("ovf_full",  32'(full), 1);
      end

      // Drain: 1..32 in order, no 99
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b1, 1'b0, 32'd0, 1'b1);
         check("drain_dout",  dout, 32'(i));
         check("drain_dv",    32'(dout_valid), 1);
         check("drain_count", 32'(count), 32'(DEPTH - i));
         check("drain_empty", 32'(empty), (i == DEPTH) ? 1 : 0);
         check("drain_af",    32'(almost_full), ((DEPTH - i) >= 28) ? 1 : 0);
      end
      step(1'b1, 1'b0, 32'd0, 1'b0);
      check("idle_dv",   32'(dout_valid), 0);
      check("idle_dout", dout, 32);
      check("idle_udf",  32'(udf), 0);

      // Underflow with simultaneous write on empty
      step(1'b1, 1'b1, 32'd7, 1'b1);
      check("udf_count", 32'(count), 1);
      check("udf_flag",  32'(udf), 1);
      check("udf_dv",    32'(dout_valid), 0);
      check("udf_empty", 32'(empty), 0);
      check("udf_dout",  dout, 32);
      step(1'b1, 1'b0, 32'd0, 1'b1);
      check("udf_rd_dout",  dout, 7);
      check("udf_rd_dv",    32'(dout_valid), 1);
      check("udf_rd_empty", 32'(empty), 1);

      // Streaming with a 5-cycle ce freeze in the middle
      vecs[0]  = mk(1, 1, 0,   1, 1, 7, 0, 0, 0, 0);
      vecs[1]  = mk(1, 1, 0,   2, 2, 7, 0, 0, 0, 0);
      vecs[2]  = mk(1, 1, 0,   3, 3, 7, 0, 0, 0, 0);
      vecs[3]  = mk(1, 1, 1,   4, 3, 1, 1, 0, 0, 0);
      vecs[4]  = mk(1, 1, 1,   5, 3, 2, 1, 0, 0, 0);
      vecs[5]  = mk(1, 1, 1,   6, 3, 3, 1, 0, 0, 0);
      vecs[6]  = mk(0, 1, 1, 100, 3, 3, 1, 0, 0, 0);
      vecs[7]  = mk(0, 1, 0, 101, 3, 3, 1, 0, 0, 0);
      vecs[8]  = mk(0, 0, 1, 102, 3, 3, 1, 0, 0, 0);
      vecs[9]  = mk(0, 0, 0, 103, 3, 3, 1, 0, 0, 0);
      vecs[10] = mk(0, 1, 1, 104, 3, 3, 1, 0, 0, 0);
      vecs[11] = mk(1, 1, 1,   7, 3, 4, 1, 0, 0, 0);
      vecs[12] = mk(1, 1, 1,   8, 3, 5, 1, 0, 0, 0);
      vecs[13] = mk(1, 0, 0,   0, 3, 5, 0, 0, 0, 0);
      for (int i = 0; i < 14; i++) begin
         step(vecs[i].ce, vecs[i].wr, vecs[i].din, vecs[i].rd);
         check("vec_count", 32'(count), 32'(vecs[i].cnt));
         check("vec_dout",  dout, vecs[i].dout);
         check("vec_dv",    32'(dout_valid), 32'(vecs[i].dv));
         check("vec_full",  32'(full), 32'(vecs[i].full));
         check("vec_empty", 32'(empty), 32'(vecs[i].empty));
         check("vec_af",    32'(almost_full), 32'(vecs[i].af));
      end
      for (int d = 9; d <= 20; d++) begin
         step(1'b1, 1'b1, 32'(d), 1'b1);
         check("stream_dout",  dout, 32'(d - 3));
         check("stream_count", 32'(count), 3);
      end
      for (int d = 18; d <= 20; d++) begin
         step(1'b1, 1'b0, 32'd0, 1'b1);
         check("tail_dout", dout, 32'(d));
      end
      check("tail_empty", 32'(empty), 1);

      // Reset mid-operation
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b1, 32'(10 + i), 1'b0);
      end
      check("pre_rst_count", 32'(count), 10);
      step(1'b1, 1'b0, 32'd0, 1'b1);
      check("pre_rst_dv", 32'(dout_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_count", 32'(count), 0);
      check("mid_rst_empty", 32'(empty), 1);
      check("mid_rst_ovf",   32'(ovf), 0);
      check("mid_rst_udf",   32'(udf), 0);
      check("mid_rst_dv",    32'(dout_valid), 0);
      check("mid_rst_dout",  dout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b1, 32'd55, 1'b0);
      check("post_rst_count", 32'(count), 1);
      step(1'b1, 1'b0, 32'd0, 1'b1);
      check("post_rst_dout", dout, 55);
      check("post_rst_dv",   32'(dout_valid), 1);
      check("post_rst_empty", 32'(empty), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/srl_fifo.md
Name: srl_fifo

Overview:
- Parametrised successor to the fixed-depth `srl` delay line.
- Shift-register FIFO: writes shift into a CE-gated shift-register array; reads are addressed dynamically at occupancy-1. This maps to SRLC32E primitives with no BRAM.
- Adds valid/ready-style flow control, occupancy count, an almost-full threshold and error flags.
- Sits between PE stages to buffer `DATA_WIDTH*2`-bit complex samples when producer and consumer rates differ.

Parameters:
- WIDTH, `DATA_WIDTH*2` (32): data word width in bits.
- DEPTH, 32: number of entries. Power of two, 2..128.
- AW, $clog2(DEPTH): internal read-address width.
- AF_LEVEL, DEPTH-4: count at or above which almost_full asserts.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  global clock enable; 0 freezes all state.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- rd_en  in  1  read request.
- dout  out  WIDTH  registered read data.
- dout_valid  out  1  dout holds a newly read word (one-cycle pulse per read).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  AW+1  current occupancy, 0..DEPTH.
- ovf  out  1  sticky: write attempted while full.
- udf  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst_n=0, async assert, sync-released on clk):
  - count=0, empty=1, full=0, almost_full=0 (unless AF_LEVEL==0).
  - dout=0, dout_valid=0, ovf=0, udf=0.
  - Storage array is NOT reset, so it still maps to SRL. Its contents are don't-care.
- Accept rules, evaluated on each rising edge with ce=1:
  - wr_acc = wr_en & ~full
  - rd_acc = rd_en & ~empty
- Write:
  - On wr_acc, mem[0]<=din and mem[i]<=mem[i-1] for all i.
  - The oldest entry is always at index count-1.
- Read:
  - On rd_acc, dout<=mem[count-1] using the pre-edge count and pre-shift contents.
  - dout_valid<=1 on that edge.
  - Read latency: one clock from the rd_en edge to dout/dout_valid.
  - dout holds its value until the next accepted read. dout_valid clears on the next edge with ce=1 and no rd_acc.
- Count update:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - Both: unchanged. Simultaneous read and write are legal at any non-boundary occupancy, and the read returns the pre-shift oldest word.
- Boundaries:
  - Full with wr_en & rd_en: only the read is accepted; count becomes DEPTH-1 and ovf is set.
  - Empty with wr_en & rd_en: only the write is accepted; count becomes 1, udf is set, dout_valid=0.
- Flags:
  - full, empty and almost_full are registered, derived from the next count value, and valid in the same cycle count updates.
  - ovf/udf set on wr_en&full or rd_en&empty with ce=1, and clear only on reset.
- ce=0: no shift, no count change, no flag change. dout and dout_valid hold their current values (dout_valid is not cleared).
- Reset mid-operation: all control state clears immediately. Stale storage is never observable because empty=1 blocks reads.
- No wrap-around pointers: the dynamic address only ever spans 0..DEPTH-1.

Decomposition:
- parameters.vh:
  - DATA_WIDTH (existing).
  - New SRL_FIFO_DEPTH default.
  - SRL_FIFO_AF_MARGIN (4).
- Sub-module srl_mem:
  - Ports: clk, ce, shift, din, addr[AW-1:0], q.
  - Pure shift array with combinational addressed read, no reset.
  - Instantiated once in srl_fifo; the synthesis target for SRLC32E.
- srl_fifo holds the counter, accept logic, output register and flags.

Test Plan:
- Fill/drain:
  - After reset, ce=1, write 1..32 on consecutive cycles: count reaches 32, full=1 after the 32nd edge, almost_full=1 from count 28.
  - Then read 32 times: dout=1,2,...,32 each one cycle after rd_en, empty=1 after the last read.
- Overflow: on a full FIFO, hold wr_en with din=99 for 3 cycles. Count stays 32, ovf=1, contents unchanged; a subsequent drain yields 1..32 with no 99.
- Underflow, read and write: on an empty FIFO, apply rd_en with wr_en and din=7 for one cycle. Expect count=1, udf=1, dout_valid=0; the next read returns 7.
- Streaming: preload 1,2,3, then do simultaneous wr/rd with din=4..20. dout sequence is 1,2,3,4,...; count holds at 3 throughout.
- ce gating: during a stream, drop ce for 5 cycles while toggling wr_en/rd_en. Count, dout, dout_valid and flags are frozen; the sequence resumes without a lost or duplicated word.
- Reset mid-operation: with count=10, pulse rst_n low asynchronously (between edges). Outputs clear immediately: count=0, empty=1, ovf=udf=0. A new write of 55 followed by a read returns 55.
